// File: rtl/edge_spike_encoder.sv
// Integrate-and-fire rate encoder: captures one tile of edge magnitudes and
// streams one spike bit per pixel per timestep over a valid/ready link.
module edge_spike_encoder #(
    parameter int TILE_PIXELS = 256,
    parameter int NUM_STEPS   = 8,
    parameter int THRESHOLD   = 256,
    parameter int IDX_W       = $clog2(TILE_PIXELS),
    parameter int TS_W        = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1,
    parameter int MEM_W       = $clog2(THRESHOLD + 256)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [7:0]       iData,
    input  logic             iValid,
    output logic             oSpike,
    output logic             oSpikeValid,
    input  logic             iSpikeReady,
    output logic [IDX_W-1:0] oPixelIdx,
    output logic [TS_W-1:0]  oTimeStep,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDropErr
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ENCODE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TILE_PIXELS - 1);
    localparam logic [TS_W-1:0]  LAST_STEP = TS_W'(NUM_STEPS - 1);
    localparam logic [MEM_W-1:0] THR       = MEM_W'(THRESHOLD);
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [TS_W-1:0]  TS_ZERO   = {TS_W{1'b0}};

    logic [7:0]       pix_buf [TILE_PIXELS];
    logic [MEM_W-1:0] mem     [TILE_PIXELS];

    logic [1:0]       state_r;
    logic [IDX_W-1:0] load_cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [TS_W-1:0]  step_r;
    logic             spike_r;
    logic             spike_valid_r;
    logic             busy_r;
    logic             done_r;
    logic             drop_err_r;

    logic             hs_s;
    logic             last_hs_s;
    logic             last_load_s;
    logic             cap_s;
    logic [IDX_W-1:0] cap_addr_s;
    logic [IDX_W-1:0] idx_nxt_s;
    logic [TS_W-1:0]  step_nxt_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [MEM_W-1:0] cur_sum_s;
    logic [MEM_W-1:0] rd_sum_s;
    logic [MEM_W-1:0] upd_s;

    // Handshake, capture decode, next-index and membrane arithmetic
    always_comb begin
        hs_s        = spike_valid_r & iSpikeReady;
        last_hs_s   = hs_s && (idx_r == LAST_IDX) && (step_r == LAST_STEP);
        last_load_s = (state_r == ST_LOAD) && iValid && (load_cnt_r == LAST_IDX);
        cap_s       = 1'b0;
        cap_addr_s  = load_cnt_r;
        case (state_r)
            ST_IDLE: begin
                cap_s      = iStart & iValid;
                cap_addr_s = IDX_ZERO;
            end
            ST_LOAD: begin
                cap_s      = iValid;
                cap_addr_s = load_cnt_r;
            end
            default: begin
                cap_s      = 1'b0;
                cap_addr_s = load_cnt_r;
            end
        endcase
        if (idx_r == LAST_IDX) begin
            idx_nxt_s  = IDX_ZERO;
            step_nxt_s = step_r + TS_W'(1);
        end else begin
            idx_nxt_s  = idx_r + IDX_W'(1);
            step_nxt_s = step_r;
        end
        // The next pixel's sum is precomputed so the spike output can be registered.
        if (last_load_s) begin
            rd_idx_s = IDX_ZERO;
        end else begin
            rd_idx_s = idx_nxt_s;
        end
        cur_sum_s = mem[idx_r] + MEM_W'(pix_buf[idx_r]);
        rd_sum_s  = mem[rd_idx_s] + MEM_W'(pix_buf[rd_idx_s]);
        if (spike_r) begin
            upd_s = cur_sum_s - THR;
        end else begin
            upd_s = cur_sum_s;
        end
    end

    // Pixel and membrane storage; intentionally not reset
    always_ff @(posedge iClk) begin
        if (iRst && cap_s) begin
            pix_buf[cap_addr_s] <= iData;
            mem[cap_addr_s]     <= {MEM_W{1'b0}};
        end else if (iRst && hs_s) begin
            mem[idx_r] <= upd_s;
        end
    end

    // Control FSM and registered outputs
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_r       <= ST_IDLE;
            load_cnt_r    <= IDX_ZERO;
            idx_r         <= IDX_ZERO;
            step_r        <= TS_ZERO;
            spike_r       <= 1'b0;
            spike_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            drop_err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (iStart) begin
                        state_r    <= ST_LOAD;
                        busy_r     <= 1'b1;
                        drop_err_r <= 1'b0;
                        load_cnt_r <= iValid ? IDX_W'(1) : IDX_ZERO;
                    end else if (iValid) begin
                        drop_err_r <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (iValid) begin
                        load_cnt_r <= load_cnt_r + IDX_W'(1);
                    end
                    if (last_load_s) begin
                        state_r       <= ST_ENCODE;
                        idx_r         <= IDX_ZERO;
                        step_r        <= TS_ZERO;
                        spike_valid_r <= 1'b1;
                        spike_r       <= (rd_sum_s >= THR);
                    end
                end
                ST_ENCODE: begin
                    if (iValid) begin
                        drop_err_r <= 1'b1;
                    end
                    if (last_hs_s) begin
                        state_r       <= ST_DONE;
                        spike_valid_r <= 1'b0;
                        spike_r       <= 1'b0;
                        idx_r         <= IDX_ZERO;
                        step_r        <= TS_ZERO;
                        done_r        <= 1'b1;
                    end else if (hs_s) begin
                        idx_r   <= idx_nxt_s;
                        step_r  <= step_nxt_s;
                        spike_r <= (rd_sum_s >= THR);
                    end
                end
                ST_DONE: begin
                    if (iValid) begin
                        drop_err_r <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    busy_r        <= 1'b0;
                    spike_valid_r <= 1'b0;
                    spike_r       <= 1'b0;
                end
            endcase
        end
    end

    assign oSpike      = spike_r;
    assign oSpikeValid = spike_valid_r;
    assign oPixelIdx   = idx_r;
    assign oTimeStep   = step_r;
    assign oBusy       = busy_r;
    assign oDone       = done_r;
    assign oDropErr    = drop_err_r;

endmodule

// File: tb/tb_edge_spike_encoder.sv
// Randomized self-checking bench for edge_spike_encoder against a closed-form
// rate-coding reference (spike at step s iff floor((s+1)p/T) > floor(sp/T)).
module tb_edge_spike_encoder;
    localparam int TP = 256;
    localparam int NS = 8;
    localparam int TH = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = 8'd0;
    logic       valid = 1'b0;
    logic       spike;
    logic       spike_valid;
    logic       spike_ready = 1'b1;
    logic [7:0] pixel_idx;
    logic [2:0] time_step;
    logic       busy;
    logic       done;
    logic       drop_err;

    int total = 0;
    int bad   = 0;
    int pix[TP];

    edge_spike_encoder #(.TILE_PIXELS(TP), .NUM_STEPS(NS), .THRESHOLD(TH)) dut (
        .iClk(clk), .iRst(rst), .iStart(start), .iData(data), .iValid(valid),
        .oSpike(spike), .oSpikeValid(spike_valid), .iSpikeReady(spike_ready),
        .oPixelIdx(pixel_idx), .oTimeStep(time_step), .oBusy(busy),
        .oDone(done), .oDropErr(drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_spike(input int p, input int s);
        return (((s + 1) * p) / TH) > ((s * p) / TH);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_spike"}, 32'(spike), 32'd0);
        check({tag, "_valid"}, 32'(spike_valid), 32'd0);
        check({tag, "_idx"}, 32'(pixel_idx), 32'd0);
        check({tag, "_ts"}, 32'(time_step), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_drop"}, 32'(drop_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; valid = 1'b0; spike_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_outputs_zero("reset");
    endtask

    // Called at a negedge; returns at the negedge after the last sample edge.
    task automatic load_tile(input bit start_with_valid, input bit gapped);
        int first;
        start = 1'b1;
        valid = start_with_valid;
        data  = 8'(pix[0]);
        @(negedge clk);
        start = 1'b0;
        valid = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        check("load_drop_clr", 32'(drop_err), 32'd0);
        first = start_with_valid ? 1 : 0;
        for (int i = first; i < TP; i++) begin
            int g;
            g = gapped ? int'($urandom_range(0, 3)) : 0;
            for (int k = 0; k < g; k++) begin
                valid = 1'b0;
                @(negedge clk);
            end
            check("no_early_encode", 32'(spike_valid), 32'd0);
            valid = 1'b1;
            data  = 8'(pix[i]);
            @(negedge clk);
        end
        valid = 1'b0;
        check("encode_entry", 32'(spike_valid), 32'd1);
    endtask

    // Drains a tile; rmode 1 = random ready, abort_hs >= 0 resets at that handshake count.
    task automatic encode_run(input bit rmode, input bit inject, input int abort_hs,
                              output int ncyc, output bit aborted);
        int s = 0;
        int i = 0;
        int hs = 0;
        int cyc = 0;
        int cnt[TP];
        aborted = 1'b0;
        for (int k = 0; k < TP; k++) cnt[k] = 0;
        while (hs < TP * NS && cyc < 30000) begin
            if (abort_hs >= 0 && hs == abort_hs) begin
                aborted = 1'b1;
                break;
            end
            check("spike_stream", 32'({spike_valid, spike, time_step, pixel_idx}),
                  32'({1'b1, ref_spike(pix[i], s), 3'(s), 8'(i)}));
            spike_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            valid = inject && ((cyc % 97) == 5);
            data  = 8'($urandom);
            if (spike_ready) begin
                cnt[i] += int'(spike);
                hs++;
                i++;
                if (i == TP) begin
                    i = 0;
                    s++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        valid = 1'b0;
        spike_ready = 1'b1;
        ncyc = cyc;
        if (aborted) begin
            rst = 1'b0;
            @(negedge clk);
            check_outputs_zero("abort");
            rst = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("abort_no_done", 32'({done, busy}), 32'd0);
            end
        end else begin
            check("encode_budget", 32'(hs), 32'(TP * NS));
            check("final_valid_low", 32'(spike_valid), 32'd0);
            check("done_pulse", 32'({done, busy}), 32'b11);
            for (int k = 0; k < TP; k++) begin
                if (cnt[k] != (NS * pix[k]) / TH)
                    check("spike_count", 32'(cnt[k]), 32'((NS * pix[k]) / TH));
            end
            check("spike_count_p0", 32'(cnt[0]), 32'((NS * pix[0]) / TH));
            @(negedge clk);
            check("done_end", 32'({done, busy}), 32'd0);
        end
    endtask

    initial begin
        int  ncyc;
        bit  ab;

        do_reset();

        // Uniform tile of 128, ready held high
        for (int k = 0; k < TP; k++) pix[k] = 128;
        load_tile(1'b0, 1'b0);
        encode_run(1'b0, 1'b0, -1, ncyc, ab);
        check("uniform_cycles", 32'(ncyc), 32'(TP * NS));

        // Extremes
        for (int k = 0; k < TP; k++) pix[k] = 64;
        pix[0] = 255;
        pix[1] = 0;
        load_tile(1'b0, 1'b0);
        encode_run(1'b0, 1'b0, -1, ncyc, ab);

        // Ramp tile, first with ready high then with random backpressure
        for (int k = 0; k < TP; k++) pix[k] = k;
        load_tile(1'b0, 1'b0);
        encode_run(1'b0, 1'b0, -1, ncyc, ab);
        load_tile(1'b0, 1'b1);
        encode_run(1'b1, 1'b0, -1, ncyc, ab);

        // Protocol: stray iValid in IDLE and ENCODE, iStart together with iValid
        valid = 1'b1;
        data  = 8'hAA;
        @(negedge clk);
        valid = 1'b0;
        check("idle_drop_set", 32'(drop_err), 32'd1);
        for (int k = 0; k < TP; k++) pix[k] = int'($urandom_range(0, 255));
        load_tile(1'b1, 1'b0);
        encode_run(1'b1, 1'b1, -1, ncyc, ab);
        check("encode_drop_set", 32'(drop_err), 32'd1);

        // Gapped load of a random tile; start clears the sticky error
        for (int k = 0; k < TP; k++) pix[k] = int'($urandom_range(0, 255));
        load_tile(1'b0, 1'b1);
        encode_run(1'b1, 1'b0, -1, ncyc, ab);

        // Reset mid-ENCODE at step 3, then a fresh tile from step 0
        load_tile(1'b0, 1'b0);
        encode_run(1'b1, 1'b0, 3 * TP, ncyc, ab);
        check("abort_taken", 32'(ab), 32'd1);
        for (int k = 0; k < TP; k++) pix[k] = int'($urandom_range(0, 255));
        load_tile(1'b0, 1'b1);
        encode_run(1'b0, 1'b0, -1, ncyc, ab);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
